// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO in front of the UART transmitter. Bytes are pushed
// at core speed and issued one at a time. A new byte goes out only after the
// transmitter STATUS has fallen and then returned high.
module uart_tx_queue #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          clr_ovf,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          busy,
   output logic [7:0]    tx_data,
   output logic          tx_en,
   input  logic          tx_status
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t        state, state_next;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   // Flags are decoded from the registered count, so they change only on an edge.
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign busy  = (state != IDLE) || !empty;

   // A push is rejected whenever the queue is full. A pop in the same cycle
   // does not make room for it.
   assign push = wr_en && !full;

   // Issue FSM next state. A pop happens only from IDLE, when a byte is waiting
   // and the transmitter reports idle.
   always_comb begin
      // NOTE: give every always_comb output a default first. Any path that
      // leaves a signal unassigned infers a latch.
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && tx_status) begin
               pop        = 1'b1;
               state_next = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!tx_status) state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_status) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state always uses non-blocking (<=) assignments.
      // Every register then samples its pre-edge value, and the outcome does
      // not depend on process ordering.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset. The pointers and count
      // already make any stale contents unreachable, and leaving the array out
      // of reset lets it map onto plain registers or distributed RAM.
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy count and the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // When a rejected push and a clear arrive together, the set wins.
         if (wr_en && full) overflow <= 1'b1;
         else if (clr_ovf)  overflow <= 1'b0;
      end
   end

   // Transmitter interface. The strobe lasts one cycle, and the data holds
   // until the next pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_en   <= 1'b0;
         tx_data <= 8'h00;
      end else begin
         tx_en <= pop;
         if (pop) tx_data <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue. It includes a small UART transmitter
// model with a short bit time, plus a strobe monitor.
module tb_uart_tx_queue;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int BIT   = 4;   // cycles per bit in the transmitter model

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          clr_ovf = 1'b0;
   logic          full, empty, overflow, busy, tx_en;
   logic [AW:0]   count;
   logic [7:0]    tx_data;
   logic          tx_status;

   logic          model_on = 1'b1;
   logic          manual_status = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
      .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy),
      .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status)
   );

   // Transmitter model: latches DATA on EN, shifts a 10-bit frame LSB first
   logic       m_busy;
   logic [9:0] m_frame;
   logic [3:0] m_bit;
   int         m_cyc;
   logic       line_log [$];

   assign tx_status = model_on ? !m_busy : manual_status;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_frame <= '1;
         m_bit   <= '0;
         m_cyc   <= 0;
      end else if (m_busy) begin
         if (m_cyc == BIT-1) begin
            m_cyc <= 0;
            if (m_bit == 4'd9) begin
               m_busy <= 1'b0;
            end else begin
               m_bit <= m_bit + 4'd1;
               line_log.push_back(m_frame[m_bit + 4'd1]);
            end
         end else begin
            m_cyc <= m_cyc + 1;
         end
      end else if (model_on && tx_en) begin
         m_busy  <= 1'b1;
         m_frame <= {1'b1, tx_data, 1'b0};
         m_bit   <= '0;
         m_cyc   <= 0;
         line_log.push_back(1'b0);
      end
   end

   // Strobe monitor: logs issued bytes and counts handshake violations
   logic [7:0] issued [$];
   int   strobe_low = 0, dbl_strobe = 0, early_strobe = 0;
   logic prev_en, prev_status, armed;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         prev_en     <= 1'b0;
         prev_status <= 1'b1;
         armed       <= 1'b1;
      end else begin
         if (tx_en) begin
            issued.push_back(tx_data);
            if (tx_status !== 1'b1) strobe_low <= strobe_low + 1;
            if (prev_en) dbl_strobe <= dbl_strobe + 1;
            if (!armed && !(!prev_status && tx_status)) early_strobe <= early_strobe + 1;
            armed <= 1'b0;
         end else if (!prev_status && tx_status) begin
            armed <= 1'b1;
         end
         prev_en     <= tx_en;
         prev_status <= tx_status;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", full); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (tx_status !== 1'b1) begin n_bad++; $display("FAIL reset_tx_status: got %b expected 1", tx_status); end
   endtask

   task automatic test_single();
      logic exp_line [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      model_on = 1'b1;
      line_log.delete();
      issued.delete();
      wr_en = 1'b1; wr_data = 8'hA5;
      step();                                   // E0: push
      wr_en = 1'b0;
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL single_count_after_push: got %0d expected 1", count); end
      n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL single_no_early_strobe: got %b expected 0", tx_en); end
      step();                                   // E1: pop
      n_cmp++; if (tx_en !== 1'b1) begin n_bad++; $display("FAIL single_strobe: got %b expected 1", tx_en); end
      n_cmp++; if (tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", tx_data); end
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty_after_pop: got %b expected 1", empty); end
      step();                                   // E2
      n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL single_strobe_width: got %b expected 0", tx_en); end
      for (int c = 0; c < 200 && (line_log.size() < 10 || busy || !tx_status); c++) step();
      n_cmp++; if (line_log.size() != 10) begin n_bad++; $display("FAIL single_line_len: got %0d expected 10", line_log.size()); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (line_log[i] !== exp_line[i]) begin n_bad++; $display("FAIL single_line_bit%0d: got %b expected %b", i, line_log[i], exp_line[i]); end
      end
      n_cmp++; if (issued.size() != 1) begin n_bad++; $display("FAIL single_strobe_count: got %0d expected 1", issued.size()); end
   endtask

   task automatic test_burst();
      model_on = 1'b1;
      issued.delete();
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      for (int c = 0; c < 1000 && (issued.size() < 5 || busy || !tx_status); c++) step();
      n_cmp++; if (issued.size() != 5) begin n_bad++; $display("FAIL burst_count: got %0d expected 5", issued.size()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (issued[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL burst_order%0d: got %h expected %h", i, issued[i], 8'(i + 1)); end
      end
      n_cmp++; if (strobe_low != 0) begin n_bad++; $display("FAIL burst_strobe_while_sending: got %0d expected 0", strobe_low); end
      n_cmp++; if (early_strobe != 0) begin n_bad++; $display("FAIL burst_strobe_before_return: got %0d expected 0", early_strobe); end
      n_cmp++; if (dbl_strobe != 0) begin n_bad++; $display("FAIL burst_double_strobe: got %0d expected 0", dbl_strobe); end
   endtask

   task automatic test_full_overflow();
      model_on = 1'b0; manual_status = 1'b0;
      step();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         step();
         if (i == DEPTH - 2) begin
            n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_at_15: got %b expected 0", full); end
         end
      end
      n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_at_16: got %b expected 1", full); end
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL count_at_16: got %0d expected 16", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_before_17th: got %b expected 0", overflow); end
      wr_data = 8'hEE;                          // 17th push, dropped
      step();
      wr_en = 1'b0;
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL count_after_17th: got %0d expected 16", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_set: got %b expected 1", overflow); end
      repeat (3) step();
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
      wr_en = 1'b1; wr_data = 8'hEF; clr_ovf = 1'b1;
      step();
      wr_en = 1'b0; clr_ovf = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_set_wins: got %b expected 1", overflow); end
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL count_after_set_wins: got %0d expected 16", count); end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      issued.delete();
      model_on = 1'b1;
      for (int c = 0; c < 2000 && (issued.size() < DEPTH || busy || !tx_status); c++) step();
      n_cmp++; if (issued.size() != DEPTH) begin n_bad++; $display("FAIL drain_count: got %0d expected 16", issued.size()); end
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (issued[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL drain_order%0d: got %h expected %h", i, issued[i], 8'h10 + 8'(i)); end
      end
   endtask

   task automatic test_push_pop_same_edge();
      model_on = 1'b0; manual_status = 1'b0;
      step();
      wr_en = 1'b1; wr_data = 8'h77;
      step();
      wr_en = 1'b0;
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL simul_setup_count: got %0d expected 1", count); end
      issued.delete();
      manual_status = 1'b1; wr_en = 1'b1; wr_data = 8'h3C;
      step();                                   // pop 77 and push 3C together
      wr_en = 1'b0;
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL simul_count: got %0d expected 1", count); end
      n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL simul_empty: got %b expected 0", empty); end
      n_cmp++; if (tx_data !== 8'h77) begin n_bad++; $display("FAIL simul_first_data: got %h expected 77", tx_data); end
      manual_status = 1'b0; step();
      manual_status = 1'b1; step();
      step();
      n_cmp++; if (tx_en !== 1'b1) begin n_bad++; $display("FAIL simul_second_strobe: got %b expected 1", tx_en); end
      n_cmp++; if (tx_data !== 8'h3C) begin n_bad++; $display("FAIL simul_next_byte: got %h expected 3c", tx_data); end
      manual_status = 1'b0; step();
      manual_status = 1'b1; step(); step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL simul_idle_after: got %b expected 0", busy); end
   endtask

   task automatic test_wrap();
      model_on = 1'b1;
      issued.delete();
      for (int i = 0; i < 40; i++) begin
         wr_en = 1'b0;
         for (int c = 0; c < 500 && full; c++) step();
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      for (int c = 0; c < 4000 && (issued.size() < 40 || busy || !tx_status); c++) step();
      n_cmp++; if (issued.size() != 40) begin n_bad++; $display("FAIL wrap_count: got %0d expected 40", issued.size()); end
      for (int i = 0; i < 40; i++) begin
         n_cmp++; if (issued[i] !== 8'(i)) begin n_bad++; $display("FAIL wrap_order%0d: got %h expected %h", i, issued[i], 8'(i)); end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_no_overflow: got %b expected 0", overflow); end
      n_cmp++; if (strobe_low != 0 || dbl_strobe != 0 || early_strobe != 0) begin
         n_bad++; $display("FAIL wrap_handshake: got low=%0d dbl=%0d early=%0d expected all 0", strobe_low, dbl_strobe, early_strobe);
      end
   endtask

   task automatic test_reset_mid_frame();
      int snap;
      model_on = 1'b0; manual_status = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      manual_status = 1'b1; step();             // pop A1 -> WAIT_BUSY
      manual_status = 1'b0; step();             // -> WAIT_DONE
      n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL rstmid_setup_count: got %0d expected 3", count); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_setup_busy: got %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d expected 0", count); end
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got empty=%b full=%b expected 1 0", empty, full); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
      n_cmp++; if (tx_en !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_en_ovf: got en=%b ovf=%b expected 0 0", tx_en, overflow); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      step(); step();
      rst = 1'b0;
      manual_status = 1'b1;
      snap = issued.size();
      repeat (10) step();
      n_cmp++; if (issued.size() != snap) begin n_bad++; $display("FAIL rstmid_no_strobe: got %0d strobes expected 0", issued.size() - snap); end
      wr_en = 1'b1; wr_data = 8'h5A;
      step();
      wr_en = 1'b0;
      step();
      n_cmp++; if (tx_en !== 1'b1 || tx_data !== 8'h5A) begin n_bad++; $display("FAIL rstmid_new_push: got en=%b data=%h expected 1 5a", tx_en, tx_data); end
      manual_status = 1'b0; step();
      manual_status = 1'b1; step(); step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_full_overflow();
      test_push_pop_same_edge();
      test_wrap();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO and issue controller that sits directly upstream of the UART transmitter in the pipeline's peripheral path. The CPU-side store logic pushes bytes at core speed. The queue hands them one at a time to the transmitter's `DATA`/`EN` inputs, and issues the next byte only after the transmitter's `STATUS` has dropped and then returned high. It absorbs bursts of `printf`-style output, so the pipeline stalls only when the queue is full.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.
- `AW`, 4: log2(`DEPTH`); pointer width.
- `clk` in 1: system clock, 27 MHz, the same clock as the transmitter.
- `rst` in 1: reset; asynchronous and active-high.
- `wr_en` in 1: push request, sampled on the `clk` rising edge.
- `wr_data` in 8: byte to push.
- `clr_ovf` in 1: clears the sticky `overflow` flag.
- `full` out 1: high when count == `DEPTH`.
- `empty` out 1: high when count == 0.
- `count` out AW+1: number of bytes currently stored.
- `overflow` out 1: sticky flag; set when a push is attempted while full.
- `busy` out 1: high when the FSM is not IDLE or the queue is not empty.
- `tx_data` out 8: byte driven to the transmitter's `DATA` input.
- `tx_en` out 1: one-cycle load strobe driven to the transmitter's `EN` input.
- `tx_status` in 1: transmitter `STATUS`; 1 means idle, 0 means sending.

## Operation
- Storage: `DEPTH` x 8 register array with `AW`-bit read and write pointers. Pointers wrap modulo `DEPTH` with no special case.
- Push: when `wr_en` is high and `full` is low, the byte is written at `wr_ptr` and `wr_ptr` increments.
- Push while full: the byte is dropped, the pointers are unchanged, and `overflow` is set to 1. The push is rejected even if a pop occurs in the same cycle.
- `overflow` clears only when `clr_ovf` is high. If `clr_ovf` and an overflowing push occur in the same cycle, the set wins.
- `count` arithmetic per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- `full` and `empty` are decoded combinationally from the registered `count`.
- Issue FSM, three states:
  - IDLE: if `empty` is low and `tx_status` is 1, then pop: `tx_data` <= mem[`rd_ptr`], `rd_ptr`++, `tx_en` <= 1, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `tx_en` <= 0 unconditionally. If `tx_status` is 0, go to WAIT_DONE; otherwise stay.
  - WAIT_DONE: if `tx_status` is 1, go to IDLE; otherwise stay.
- `tx_data` holds its value until the next pop.
- `tx_en` is never high for two consecutive cycles.
- Reset values: state IDLE, both pointers 0, `count` 0, `full` 0, `empty` 1, `overflow` 0, `tx_en` 0, `tx_data` 8'h00, `busy` 0.
- Storage array contents are not reset.
- Reset mid-operation: all queued bytes are discarded and the FSM returns to IDLE. The transmitter shares `rst` and also returns to idle, so no handshake is left dangling.

## Timing
- Edges are numbered E0, E1, ... Let E0 be the edge that samples the push into an empty queue while the transmitter is idle.
- `count` = 1 after E0.
- At E1 the FSM pops; `tx_en` is high between E1 and E2.
- The transmitter samples `EN` at E2; its `STATUS` falls after E2.
- At E2 the FSM is in WAIT_BUSY, still sees `tx_status` = 1, and stays.
- At E3 the FSM sees `tx_status` = 0 and moves to WAIT_DONE.
- Push-to-strobe latency is 1 cycle after the push edge.
- After `tx_status` returns to 1, the FSM enters IDLE on the next edge and can pop on the edge after that. Inter-byte gap is therefore 2 cycles, which is negligible against about 10 x 2813 cycles per frame.
- `tx_status` is already high out of reset, so no warm-up is needed.
- Pop from the final entry: `empty` = 1 after the pop edge.
- A push in the same cycle as that pop leaves `count` = 1 and `empty` = 0.

## Test plan
- Single byte: after reset, push 8'hA5 while `tx_status` = 1.
  - Required: `tx_en` high for exactly 1 cycle, 1 cycle after the push, with `tx_data` = 8'hA5.
  - Required: `count` goes 1 -> 0.
  - With the transmitter model attached, the line carries 0,1,0,1,0,0,1,0,1,1.
- Burst order: push 8'h01..8'h05 back-to-back.
  - Required: `tx_en` strobes carry 01, 02, 03, 04, 05 in order.
  - Required: each strobe comes only after the previous `tx_status` 0 -> 1 return; no strobe occurs while `tx_status` = 0.
- Full and overflow: with `tx_status` held at 0 by the bench, push 17 bytes at `DEPTH` = 16.
  - Required: `full` = 1 after the 16th push.
  - Required: the 17th push is dropped, `count` stays 16, and `overflow` = 1 until `clr_ovf` is pulsed.
  - Release `tx_status`; required: 16 bytes drain in push order.
- Simultaneous push and pop: with `count` = 1 and the FSM in IDLE, push 8'h3C on the pop edge.
  - Required: `count` stays 1, `empty` stays 0, and 8'h3C is the next byte issued.
- Pointer wrap: push and drain 40 bytes, each value equal to its index.
  - Required: the output sequence is 0..39 exactly across two pointer wraps.
- Reset mid-frame: assert `rst` while in WAIT_DONE with `count` = 3.
  - Required: all outputs return to their reset values immediately; no `tx_en` occurs until a new push.
